cla_nibble_seq_adder: RTL and testbench
=======================================

// Module: cla_nibble_seq_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder built on one shared lca_4 4-bit carry-lookahead slice.
//   Captures an operand pair via valid/ready, then sequences the lca_4 over one nibble
//   per cycle, LSB nibble first, rippling carry through a register.
//   Presents sum, carry-out and signed overflow via valid/ready to the downstream consumer.
//   Used where wide adds are infrequent and area matters more than latency.
// PARAMETERS
//   WIDTH   16   operand/sum width in bits; must be a multiple of 4 and >= 4
//   NIB     WIDTH/4 (localparam)   nibble count = RUN cycles per add
// PORTS
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operand pair and cin valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in to nibble 0
//   out_valid  out  1      sum/cout/ovf valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  registered a+b+cin, low WIDTH bits
//   cout       out  1      carry out of bit WIDTH-1
//   ovf        out  1      two's-complement overflow
// BEHAVIOUR
//   Reset (async, while rst=1): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0,
//     idx=0, carry reg=0, operand regs=0. Reset mid-RUN/DONE aborts; result is lost, no out_valid.
//   FSM: IDLE -> RUN on (in_valid & in_ready); RUN -> DONE when idx==NIB-1;
//     DONE -> IDLE on out_ready. No other transitions.
//   IDLE: in_ready=1. On accept: latch a, b; carry<=cin; idx<=0; sum<=0.
//   RUN: in_ready=0. lca_4 fed A_in=a_q[4*idx+:4], B_in=b_q[4*idx+:4], C_1=carry.
//     Each cycle: sum[4*idx+:4]<=S; carry<=CO; idx<=idx+1 (idx stops at NIB-1).
//   Last RUN cycle also: cout<=CO; ovf<=(a_q[W-1]==b_q[W-1]) & (S[3]!=a_q[W-1]).
//   DONE: out_valid=1. sum/cout/ovf held stable until out_ready sampled high.
//   Latency: accept on edge k -> out_valid high after edge k+NIB (NIB RUN cycles).
//   Throughput: one add per NIB+2 cycles min. No accept in the DONE->IDLE handoff cycle;
//     in_ready rises the cycle after the output handshake.
//   in_valid/a/b/cin are ignored outside IDLE; out_ready ignored outside DONE.
//   sum/cout/ovf keep their last values after the output handshake until the next accept.
//   Arithmetic is modulo 2^WIDTH; cout is the true carry; ovf only flags signed overflow.
//   in_ready and out_valid are decoded from registered state only (no comb path from inputs).
// TESTING (WIDTH=16 unless stated)
//   a=16'hFFFF,b=16'h0001,cin=0 -> after 4 RUN cycles sum=16'h0000,cout=1,ovf=0, out_valid 4 edges after accept.
//   a=16'h7FFF,b=16'h0001,cin=0 -> sum=16'h8000,cout=0,ovf=1; a=16'h8000,b=16'h8000 -> sum=0,cout=1,ovf=1.
//   a=16'h1234,b=16'h4321,cin=1 -> sum=16'h5556,cout=0,ovf=0; in_ready=0 throughout RUN and DONE.
//   Hold out_ready=0 for 3 cycles in DONE -> out_valid, sum, cout, ovf stable; new in_valid not accepted.
//   Pulse rst after 2 RUN cycles -> out_valid=0, in_ready=1, sum=0 immediately; next add correct.
//   in_valid held high with 2 queued pairs, out_ready=1 -> 2nd accept exactly 1 cycle after 1st output
//     handshake; 1000 random pairs (also WIDTH=4, 32) match a+b+cin reference model.

Source files
------------

// File: rtl/cla_nibble_seq_adder.sv
// Sequential WIDTH-bit adder: one shared 4-bit carry-lookahead slice is stepped
// over the operands one nibble per cycle, LSB first, with the carry held in a register.
module cla_nibble_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready/out_valid come from registered state only, never from inputs.
  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [3:0]       nib_s;
  logic             nib_co;
  logic             last;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign last      = (idx == LAST_IDX);

  lca_4 u_lca (
    .a_in (a_q[4*idx +: 4]),
    .b_in (b_q[4*idx +: 4]),
    .c_1  (carry),
    .s    (nib_s),
    .co   (nib_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum[4*idx +: 4] <= nib_s;
          carry           <= nib_co;
          if (last) begin
            // Signed overflow: like-signed operands producing an opposite-signed MSB.
            cout  <= nib_co;
            ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (nib_s[3] != a_q[WIDTH-1]);
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// 4-bit carry-lookahead slice: all carries computed directly from generate/propagate.
module lca_4 (
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic       c_1,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a_in & b_in;
  assign p = a_in ^ b_in;

  assign c[0] = c_1;
  assign c[1] = g[0] | (p[0] & c_1);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_1);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_1);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_1);
  assign s    = p ^ c;

endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Directed table vectors plus hand-written corner sequences and a random sweep
// against an arithmetic reference for cla_nibble_seq_adder (WIDTH=16).
module tb_cla_nibble_seq_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests;
  int fails;

  // expected record: {ovf, cout, sum}
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  vec_t vecs[8];

  cla_nibble_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rc);
    logic [W:0] full;
    logic       v;
    full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
    v    = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  // One full transaction: accept, count RUN latency, compare, output handshake.
  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic [W+1:0] expv, input string tag);
    int n;
    int lat;
    logic [W+1:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    cin      = tc;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_accept_timeout"}, 32'(n), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!out_valid) check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, 32'(lat), 32'(NIB));
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    e = exp_q.pop_front();
    check({tag, "_sum"},  32'(sum),  32'(e[W-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(e[W]));
    check({tag, "_ovf"},  32'(ovf),  32'(e[W+1]));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_out_valid_after_hs"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after_hs"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;
    int acc1, acc2, hs1;
    logic [W-1:0] ra, rb;
    logic         rc;

    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_add(vecs[i].va, vecs[i].vb, vecs[i].vcin,
             {vecs[i].eovf, vecs[i].ecout, vecs[i].esum}, $sformatf("vec%0d", i));

    // DONE stall: results hold, new operands not taken.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
    @(posedge clk);
    #1 a = 16'h0101; b = 16'h0202;
    repeat (NIB) @(posedge clk);
    @(negedge clk);
    check("stall_out_valid0", 32'(out_valid), 32'd1);
    held_sum = sum; held_cout = cout; held_ovf = ovf;
    check("stall_sum0", 32'(sum), 32'h8000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_out_valid%0d", k + 1), 32'(out_valid), 32'd1);
      check($sformatf("stall_in_ready%0d", k + 1),  32'(in_ready),  32'd0);
      check($sformatf("stall_hold%0d", k + 1), 32'({held_ovf, held_cout, held_sum}),
            32'({1'b1, 1'b0, 16'h8000}));
      check($sformatf("stall_live%0d", k + 1), 32'({ovf, cout, sum}),
            32'({1'b1, 1'b0, 16'h8000}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("stall_in_ready_after", 32'(in_ready), 32'd1);
    check("stall_sum_kept", 32'(sum), 32'h8000);

    // Reset in the middle of RUN aborts the add.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_sum",       32'(sum),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NIB + 2; k++) begin
      @(negedge clk);
      if (out_valid) check("abort_spurious_out", 32'(out_valid), 32'd0);
    end
    do_add(16'h1111, 16'h2222, 1'b1, ref_model(16'h1111, 16'h2222, 1'b1), "post_abort");

    // Back-to-back: in_valid and out_ready held high with two queued pairs.
    acc1 = -1; acc2 = -1; hs1 = -1;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    a = 16'hABCD; b = 16'h1357; cin = 1'b0;
    for (int cyc = 0; cyc < 30 && acc2 < 0; cyc++) begin
      if (in_ready) begin
        if (acc1 < 0) acc1 = cyc;
        else acc2 = cyc;
      end
      if (out_valid && hs1 < 0) begin
        hs1 = cyc;
        check("b2b_sum1", 32'({ovf, cout, sum}), 32'(ref_model(16'hABCD, 16'h1357, 1'b0)));
      end
      @(posedge clk);
      #1;
      if (acc1 >= 0 && acc2 < 0) begin
        a = 16'h0F0F; b = 16'hF0F1; cin = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_second_accept_seen", 32'(acc2 >= 0), 32'd1);
    check("b2b_hs_to_accept", 32'(acc2 - hs1), 32'd1);
    check("b2b_period", 32'(acc2 - acc1), 32'(NIB + 2));
    repeat (NIB) @(posedge clk);
    @(negedge clk);
    check("b2b_out_valid2", 32'(out_valid), 32'd1);
    check("b2b_sum2", 32'({ovf, cout, sum}), 32'(ref_model(16'h0F0F, 16'hF0F1, 1'b1)));
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Random sweep against the arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 32'hFFFF));
      rb = W'($urandom_range(0, 32'hFFFF));
      rc = 1'($urandom_range(0, 1));
      do_add(ra, rb, rc, ref_model(ra, rb, rc), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
